// File: rtl/mips_loader_pkg.sv
// Shared types and frame constants for the byte-serial program loader.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_BITS      = 8;
  localparam int unsigned WORD_BITS      = BYTES_PER_WORD * BYTE_BITS;
  localparam int unsigned LEN_BITS       = 16;

  // Frame reception is in progress in these states.
  function automatic logic is_busy(input loader_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Clearable saturating idle counter; expired holds once TIMEOUT_CYCLES is reached.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Count enabled cycles, saturating at the limit; clear has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/program_loader.sv
// Byte-serial boot loader: parses LEN_HI/LEN_LO/data/CHK frames, writes
// big-endian words to program RAM and holds the core in reset until verified.
module program_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned MEMORY_DEPTH   = 256,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        prog_we,
  output logic [31:0] prog_addr,
  output logic [31:0] prog_wdata,
  output logic        core_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned WI = $clog2(MEMORY_DEPTH + 1);

  loader_state_t       state, state_next;
  logic [LEN_BITS-1:0] len;
  logic [WI-1:0]       word_index;
  logic [1:0]          byte_cnt;
  logic [23:0]         assembler;
  logic [7:0]          checksum;
  logic                busy_st;
  logic                enter_len_hi;
  logic                last_byte;
  logic                last_word;
  logic                tmo_expired;
  logic [LEN_BITS-1:0] len_now;

  assign busy_st      = is_busy(state);
  assign enter_len_hi = start && !busy_st;
  assign last_byte    = (byte_cnt == 2'd3);
  assign last_word    = ((32'(word_index) + 32'd1) == 32'(len));
  assign len_now      = {len[15:8], rx_data};

  loader_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy_st || rx_valid),
    .enable  (busy_st),
    .expired (tmo_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; an idle timeout overrides any waiting state.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) state_next = ST_LEN_HI;
      ST_LEN_HI: if (rx_valid) state_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (rx_valid) begin
          if (len_now == '0)                      state_next = ST_CHECK;
          else if (32'(len_now) > MEMORY_DEPTH)   state_next = ST_ERROR;
          else                                    state_next = ST_DATA;
        end
      end
      ST_DATA:  if (rx_valid && last_byte && last_word) state_next = ST_CHECK;
      ST_CHECK: if (rx_valid) state_next = (rx_data == checksum) ? ST_DONE : ST_ERROR;
      default:  state_next = ST_IDLE;
    endcase
    if (busy_st && !rx_valid && tmo_expired) state_next = ST_ERROR;
  end

  // Length capture, word assembly, checksum and registered RAM write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len        <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      assembler  <= '0;
      checksum   <= '0;
      prog_we    <= 1'b0;
      prog_addr  <= '0;
      prog_wdata <= '0;
    end else begin
      prog_we <= 1'b0;
      if (enter_len_hi) begin
        len        <= '0;
        word_index <= '0;
        byte_cnt   <= '0;
        assembler  <= '0;
        checksum   <= '0;
      end else if (rx_valid) begin
        case (state)
          ST_LEN_HI: len[15:8] <= rx_data;
          ST_LEN_LO: len[7:0]  <= rx_data;
          ST_DATA: begin
            checksum  <= checksum ^ rx_data;
            assembler <= {assembler[15:0], rx_data};
            byte_cnt  <= byte_cnt + 2'd1;
            if (last_byte) begin
              prog_we    <= 1'b1;
              prog_wdata <= {assembler, rx_data};
              prog_addr  <= 32'(word_index) << 2;
              word_index <= word_index + WI'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy         = busy_st;
  assign done         = (state == ST_DONE);
  assign error        = (state == ST_ERROR);
  assign core_reset_n = (state == ST_DONE);

endmodule
